// File: rtl/ssp_tx_ctrl.sv
// ssp_tx_ctrl: transmit sequencer between the TxFIFO and the SSP pins.
//   Pulls one word from the FIFO, then sends a one-bit-period frame sync
//   followed by the word MSB-first, together with a generated serial clock.
//
// Ports
//   PCLK       in   system clock, rising edge
//   CLEAR_B    in   asynchronous active-low reset
//   EN         in   transmit enable, looked at only when a frame could start
//   VALID      in   TxFIFO non-empty
//   TxDATA     in   TxFIFO read data, valid the cycle after SENT
//   SENT       out  one-cycle read strobe to the TxFIFO
//   SSPTXD     out  serial data, MSB first
//   SSPCLKOUT  out  serial clock (high first half of each bit period)
//   SSPFSSOUT  out  frame sync, one bit period before the MSB
//   SSPOE      out  pin drive enable during FRAME/SHIFT
//   BUSY       out  high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for VALID && EN
// REQ   | SENT strobe, FIFO advances
// FRAME | frame-sync bit period, word captured in its first cycle
// SHIFT | DATA_W data bit periods
module ssp_tx_ctrl #(
    parameter int DATA_W = 8,
    parameter int HALF   = 1
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic              EN,
    input  logic              VALID,
    input  logic [DATA_W-1:0] TxDATA,
    output logic              SENT,
    output logic              SSPTXD,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPOE,
    output logic              BUSY
);

    localparam int PW = (2*HALF > 2) ? $clog2(2*HALF) : 1;
    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(2*HALF - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(HALF);
    localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FRAME = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     phase, phase_nxt;
    logic [BW-1:0]     bitcnt, bitcnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              active_nxt;

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        case (state)
            IDLE: begin
                if (VALID && EN) state_nxt = REQ;
            end
            REQ: begin
                state_nxt = FRAME;
                phase_nxt = '0;
            end
            FRAME: begin
                // FIFO output settled on the edge that consumed SENT
                if (phase == '0) shreg_nxt = TxDATA;
                if (phase == PH_LAST) begin
                    state_nxt  = SHIFT;
                    phase_nxt  = '0;
                    bitcnt_nxt = BIT_TOP;
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            SHIFT: begin
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    shreg_nxt = shreg << 1;
                    if (bitcnt == '0) begin
                        state_nxt = (VALID && EN) ? REQ : IDLE;
                    end else begin
                        bitcnt_nxt = bitcnt - BW'(1);
                    end
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active_nxt = (state_nxt == FRAME) || (state_nxt == SHIFT);

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            state     <= IDLE;
            phase     <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            SENT      <= 1'b0;
            SSPTXD    <= 1'b0;
            SSPCLKOUT <= 1'b0;
            SSPFSSOUT <= 1'b0;
            SSPOE     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            bitcnt <= bitcnt_nxt;
            shreg  <= shreg_nxt;
            // Outputs are decoded from the next-state values so they are
            // registered yet aligned with the state they describe.
            SENT      <= (state_nxt == REQ);
            SSPTXD    <= (state_nxt == SHIFT) && shreg_nxt[DATA_W-1];
            SSPCLKOUT <= active_nxt && (phase_nxt < PH_HALF);
            SSPFSSOUT <= (state_nxt == FRAME);
            SSPOE     <= active_nxt;
            BUSY      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
module tb_ssp_tx_ctrl;

    logic       PCLK = 1'b0;
    logic       CLEAR_B = 1'b0;
    logic       EN = 1'b0;
    logic       VALID;
    logic [7:0] TxDATA;
    logic       SENT, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPOE, BUSY;

    logic       EN2 = 1'b0;
    logic       VALID2 = 1'b0;
    logic [7:0] TxDATA2 = 8'h00;
    logic       SENT2, SSPTXD2, SSPCLKOUT2, SSPFSSOUT2, SSPOE2, BUSY2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    ssp_tx_ctrl #(.DATA_W(8), .HALF(1)) dut (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .EN(EN), .VALID(VALID), .TxDATA(TxDATA),
        .SENT(SENT), .SSPTXD(SSPTXD), .SSPCLKOUT(SSPCLKOUT), .SSPFSSOUT(SSPFSSOUT),
        .SSPOE(SSPOE), .BUSY(BUSY));

    ssp_tx_ctrl #(.DATA_W(8), .HALF(3)) dut3 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .EN(EN2), .VALID(VALID2), .TxDATA(TxDATA2),
        .SENT(SENT2), .SSPTXD(SSPTXD2), .SSPCLKOUT(SSPCLKOUT2), .SSPFSSOUT(SSPFSSOUT2),
        .SSPOE(SSPOE2), .BUSY(BUSY2));

    // TxFIFO model: read data appears the cycle after SENT
    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr;
    assign VALID = (wr_ptr != rd_ptr);

    always @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            rd_ptr <= 4'd0;
            TxDATA <= 8'h00;
        end else if (SENT) begin
            TxDATA <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
        end
    end

    // expected per-cycle vectors {SENT,FSS,CLK,TXD,OE,BUSY}
    logic [5:0] exp1 [$];
    logic [5:0] exp2 [$];
    int runs1 [$];
    int runs2 [$];
    int sent_cyc [$];
    int run1 = 0;
    int run2 = 0;

    task automatic push_vec(input int sel, input logic [5:0] v);
        if (sel == 0) exp1.push_back(v);
        else exp2.push_back(v);
    endtask

    task automatic push_trace(input int sel, input int h, input logic [7:0] w);
        push_vec(sel, 6'b100001);
        for (int i = 0; i < 2*h; i++)
            push_vec(sel, {1'b0, 1'b1, (i < h), 1'b0, 1'b1, 1'b1});
        for (int b = 7; b >= 0; b--)
            for (int i = 0; i < 2*h; i++)
                push_vec(sel, {1'b0, 1'b0, (i < h), w[b], 1'b1, 1'b1});
    endtask

    always @(negedge PCLK) begin
        logic [5:0] got, e;
        got = {SENT, SSPFSSOUT, SSPCLKOUT, SSPTXD, SSPOE, BUSY};
        checks++;
        if (BUSY) begin
            run1++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL trace1_unexpected cyc=%0d got=%b exp=empty", cyc, got);
            end else begin
                e = exp1.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL trace1 cyc=%0d got=%b exp=%b", cyc, got, e);
                end
            end
        end else begin
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL idle1 cyc=%0d got=%b exp=000000", cyc, got);
            end
            if (run1 != 0) begin
                runs1.push_back(run1);
                run1 = 0;
            end
        end
        if (SENT) sent_cyc.push_back(cyc);
    end

    always @(negedge PCLK) begin
        logic [5:0] got, e;
        got = {SENT2, SSPFSSOUT2, SSPCLKOUT2, SSPTXD2, SSPOE2, BUSY2};
        checks++;
        if (BUSY2) begin
            run2++;
            if (exp2.size() == 0) begin
                errors++;
                $display("FAIL trace3_unexpected cyc=%0d got=%b exp=empty", cyc, got);
            end else begin
                e = exp2.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL trace3 cyc=%0d got=%b exp=%b", cyc, got, e);
                end
            end
        end else begin
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL idle3 cyc=%0d got=%b exp=000000", cyc, got);
            end
            if (run2 != 0) begin
                runs2.push_back(run2);
                run2 = 0;
            end
        end
    end

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, req);
        end
    endtask

    task automatic fifo_push(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic drain(input int sel, input int maxc);
        int n = 0;
        while (((sel == 0) ? exp1.size() : exp2.size()) != 0 && n < maxc) begin
            @(negedge PCLK);
            n++;
        end
        check_int((sel == 0) ? "drain1" : "drain3",
                  (sel == 0) ? exp1.size() : exp2.size(), 0);
        repeat (3) @(negedge PCLK);
        #1;
    endtask

    task automatic clear_logs();
        runs1.delete();
        runs2.delete();
        sent_cyc.delete();
    endtask

    int en_cyc;
    int last_run;

    initial begin
        // reset then idle
        CLEAR_B = 1'b0;
        EN = 1'b1;
        repeat (3) @(negedge PCLK);
        #1;
        check_int("reset_outputs", int'({SENT, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPOE, BUSY}), 0);
        @(negedge PCLK);
        CLEAR_B = 1'b1;
        repeat (20) @(negedge PCLK);
        #1;
        check_int("idle_no_busy_runs", runs1.size(), 0);
        check_int("idle_no_sent", sent_cyc.size(), 0);

        // single word 0xA5
        clear_logs();
        @(negedge PCLK);
        push_trace(0, 1, 8'hA5);
        fifo_push(8'hA5);
        drain(0, 40);
        check_int("single_sent_count", sent_cyc.size(), 1);
        last_run = (runs1.size() != 0) ? runs1[runs1.size()-1] : -1;
        check_int("single_busy_len", last_run, 19);

        // back-to-back 0x3C, 0xF0
        clear_logs();
        @(negedge PCLK);
        push_trace(0, 1, 8'h3C);
        push_trace(0, 1, 8'hF0);
        fifo_push(8'h3C);
        fifo_push(8'hF0);
        drain(0, 80);
        check_int("b2b_sent_count", sent_cyc.size(), 2);
        if (sent_cyc.size() == 2)
            check_int("b2b_sent_spacing", sent_cyc[1] - sent_cyc[0], 19);
        last_run = (runs1.size() != 0) ? runs1[runs1.size()-1] : -1;
        check_int("b2b_busy_len", last_run, 38);

        // EN gating with four queued words
        clear_logs();
        @(negedge PCLK);
        EN = 1'b0;
        fifo_push(8'h12);
        fifo_push(8'h34);
        fifo_push(8'h56);
        fifo_push(8'h78);
        push_trace(0, 1, 8'h12);
        @(negedge PCLK);
        EN = 1'b1;
        en_cyc = cyc;
        repeat (10) @(negedge PCLK);
        EN = 1'b0;
        repeat (30) @(negedge PCLK);
        #1;
        check_int("en_gate_one_sent", sent_cyc.size(), 1);
        if (sent_cyc.size() >= 1)
            check_int("en_first_latency", sent_cyc[0] - en_cyc, 1);
        check_int("en_word1_done", exp1.size(), 0);
        @(negedge PCLK);
        push_trace(0, 1, 8'h34);
        push_trace(0, 1, 8'h56);
        push_trace(0, 1, 8'h78);
        EN = 1'b1;
        en_cyc = cyc;
        drain(0, 100);
        check_int("en_total_sent", sent_cyc.size(), 4);
        if (sent_cyc.size() == 4) begin
            check_int("en_resume_latency", sent_cyc[1] - en_cyc, 1);
            check_int("en_resume_spacing", sent_cyc[2] - sent_cyc[1], 19);
        end

        // reset during SHIFT bit 5 of 0xFF
        clear_logs();
        @(negedge PCLK);
        EN = 1'b0;
        fifo_push(8'hFF);
        push_trace(0, 1, 8'hFF);
        @(negedge PCLK);
        EN = 1'b1;
        repeat (14) @(negedge PCLK);
        #1;
        check_int("pre_reset_active", int'({SSPTXD, SSPOE, BUSY}), 7);
        #1;
        CLEAR_B = 1'b0;
        wr_ptr = 4'd0;
        exp1.delete();
        #1;
        check_int("async_reset_outputs", int'({SENT, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPOE, BUSY}), 0);
        repeat (2) @(negedge PCLK);
        CLEAR_B = 1'b1;
        repeat (5) @(negedge PCLK);
        #1;
        check_int("post_reset_idle", int'(BUSY), 0);

        // HALF=3 instance, word 0x81
        clear_logs();
        @(negedge PCLK);
        push_trace(1, 3, 8'h81);
        TxDATA2 = 8'h81;
        EN2 = 1'b1;
        VALID2 = 1'b1;
        begin
            int n = 0;
            while (!SENT2 && n < 5) begin
                @(negedge PCLK);
                n++;
            end
            check_int("h3_sent_seen", int'(SENT2), 1);
            VALID2 = 1'b0;
        end
        drain(1, 120);
        last_run = (runs2.size() != 0) ? runs2[runs2.size()-1] : -1;
        check_int("h3_busy_len", last_run, 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ssp_tx_ctrl.md
Name: ssp_tx_ctrl

Overview:
Transmit-side controller for the SSP that sequences the TxFIFO. When the FIFO reports VALID, it requests one word with a single-cycle SENT pulse and captures TxDATA on the following cycle. It then emits a frame-sync period followed by the word serialised MSB-first, with a generated serial clock. Sits between the TxFIFO and the SSP pins, in the PCLK domain.

Parameters:
DATA_W, 8, word width; must match the TxFIFO data width.
HALF, 1, PCLK cycles per serial-clock phase (≥1); one bit period = 2*HALF PCLK cycles.

Ports:
PCLK  input  1  system clock; all state updates on its rising edge.
CLEAR_B  input  1  asynchronous active-low reset.
EN  input  1  transmit enable; sampled only when deciding to start a frame.
VALID  input  1  TxFIFO non-empty.
TxDATA  input  DATA_W  TxFIFO read data; valid the cycle after SENT was high.
SENT  output  1  registered read strobe to the TxFIFO; high for exactly one cycle per word.
SSPTXD  output  1  serial data out, MSB first.
SSPCLKOUT  output  1  serial clock out.
SSPFSSOUT  output  1  frame sync; high for one bit period before the MSB.
SSPOE  output  1  output-drive enable; high while FRAME or SHIFT is active.
BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (CLEAR_B=0, asynchronous): state=IDLE; SENT, SSPTXD, SSPCLKOUT, SSPFSSOUT, SSPOE and BUSY all 0; shift register, bit counter and phase counter cleared. This holds even mid-frame; the partial word is lost, and the FIFO is assumed reset by the same CLEAR_B.
- All outputs are registered; none is combinationally derived from inputs.
- States:
  - IDLE: if VALID && EN -> REQ.
  - REQ: exactly 1 cycle with SENT=1; -> FRAME.
  - FRAME: lasts 2*HALF cycles.
    - In the first cycle, shreg <= TxDATA (the FIFO has just updated TxDATA).
    - SSPFSSOUT=1, SSPOE=1, SSPTXD=0.
    - On completion -> SHIFT with bitcnt=DATA_W-1.
  - SHIFT: DATA_W bit periods.
    - SSPTXD = shreg[DATA_W-1]; SSPOE=1; SSPFSSOUT=0.
    - At the end of each bit period: shreg shifts left by 1 and bitcnt decrements.
    - At the end of the bit period with bitcnt=0: if VALID && EN -> REQ, else -> IDLE.
- Serial clock: in FRAME and SHIFT, SSPCLKOUT=1 for the first HALF cycles of each bit period and 0 for the last HALF cycles. It is 0 in IDLE and REQ. SSPTXD changes only at bit-period boundaries; the receiver samples on the falling edge.
- Phase counter: counts 0..2*HALF-1, restarts on entry to FRAME and at each bit boundary. Width is clog2(2*HALF), minimum 1. Bitcnt width is clog2(DATA_W).
- Latency: VALID && EN first sampled high in IDLE at edge k -> SENT high in cycle k+1 -> FSS in cycles k+2 .. k+1+2*HALF -> MSB starts at cycle k+2+2*HALF.
- Word period: 1 + 2*HALF*(DATA_W+1) cycles; 19 cycles at the defaults. Back-to-back words insert only the 1-cycle REQ gap, during which SSPOE=0 and SSPCLKOUT=0.
- EN dropped mid-word: the current word completes; no further REQ. EN toggling during FRAME or SHIFT has no effect.
- VALID falling during FRAME or SHIFT: no effect; the word is already captured.
- SENT is never asserted while VALID=0. At most one SENT per word. SENT never overlaps FRAME or SHIFT.
- FIFO empty after the last bit: controller returns to IDLE, and all outputs return to 0 on the next cycle.

Test Plan:
- Reset then idle: CLEAR_B=0 for 3 cycles, VALID=0, EN=1 -> all outputs 0; BUSY stays 0 for 20 cycles.
- Single word, defaults: FIFO holds 0xA5, EN=1.
  - SENT is high for 1 cycle.
  - SSPFSSOUT is high for 2 cycles.
  - SSPTXD carries 1,0,1,0,0,1,0,1, each for 2 cycles, with SSPCLKOUT as 1,0 per bit.
  - BUSY is high for 19 cycles, then IDLE.
- Back-to-back: FIFO holds 0x3C,0xF0 -> two SENT pulses exactly 19 cycles apart; serial stream 00111100 then 11110000 with a 1-cycle REQ gap.
- EN gating: FIFO holds 4 words, EN deasserted during bit 3 of word 1 -> word 1 completes; no second SENT until EN=1, then word 2 starts 1 cycle later.
- Reset mid-operation: assert CLEAR_B during SHIFT bit 5 -> all outputs 0 immediately (asynchronous), state IDLE.
- HALF=3, DATA_W=8, word 0x81 -> each bit lasts 6 cycles (SSPCLKOUT 1,1,1,0,0,0); total 1+6*9=55 cycles; SSPTXD high only in the first and last bit periods.
